// File: rtl/params.sv
// Shared types and sizing for the systolic array feeder path.
package params;

   localparam int unsigned N      = 8;
   localparam int unsigned K_MAX  = 256;
   localparam int unsigned KW     = $clog2(K_MAX + 1);
   localparam int unsigned WORD_W = 32;

   typedef enum logic [2:0] {
      FT_INT8  = 3'd0,
      FT_INT16 = 3'd1,
      FT_INT32 = 3'd2,
      FT_FP16  = 3'd3,
      FT_BF16  = 3'd4,
      FT_FP32  = 3'd5
   } full_type_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } feeder_state_t;

endpackage

// File: rtl/skew_line.sv
// Fixed-length {en, data} delay line with synchronous active-low clear.
module skew_line #(
   parameter int unsigned DELAY = 1,
   parameter int unsigned W     = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_in,
   input  logic [W-1:0] data_in,
   output logic         en_out,
   output logic [W-1:0] data_out
);

   logic [DELAY-1:0] en_q;
   logic [W-1:0]     data_q [DELAY];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int s = 0; s < int'(DELAY); s++) begin
            en_q[s]   <= 1'b0;
            data_q[s] <= '0;
         end
      end else begin
         en_q[0]   <= en_in;
         data_q[0] <= data_in;
         for (int s = 1; s < int'(DELAY); s++) begin
            en_q[s]   <= en_q[s-1];
            data_q[s] <= data_q[s-1];
         end
      end
   end

   assign en_out   = en_q[DELAY-1];
   assign data_out = data_q[DELAY-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Tile framer and diagonal skew stage feeding the left and top edges of the PE array.
module systolic_skew_feeder
   import params::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [KW-1:0]       k_len,
   input  full_type_t          compute_type,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WORD_W*N-1:0] a_vec,
   input  logic [WORD_W*N-1:0] b_vec,
   output logic [WORD_W*N-1:0] a_left,
   output logic [N-1:0]        enleft,
   output logic [WORD_W*N-1:0] in_b_above,
   output logic [N-1:0]        enup,
   output full_type_t          compute_type_out,
   output logic                busy,
   output logic                done
);

   localparam int unsigned CW = $clog2(N + 1);

   feeder_state_t state, state_n;
   logic [KW-1:0] remaining, remaining_n;
   logic [CW-1:0] drain_cnt, drain_n;
   full_type_t    type_n;
   logic          accept_c;

   // in_ready is a registered copy of (state == STREAM), so no path from in_valid
   assign accept_c = in_ready && in_valid;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state            <= IDLE;
         remaining        <= '0;
         drain_cnt        <= '0;
         compute_type_out <= FT_INT8;
         in_ready         <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
      end else begin
         state            <= state_n;
         remaining        <= remaining_n;
         drain_cnt        <= drain_n;
         compute_type_out <= type_n;
         in_ready         <= (state_n == STREAM);
         busy             <= (state_n != IDLE);
         done             <= (state_n == DONE);
      end
   end

   always_comb begin
      state_n     = state;
      remaining_n = remaining;
      drain_n     = drain_cnt;
      type_n      = compute_type_out;
      case (state)
         IDLE: begin
            if (start) begin
               if (k_len != '0) begin
                  remaining_n = k_len;
                  type_n      = compute_type;
                  state_n     = STREAM;
               end else begin
                  state_n = DONE;
               end
            end
         end
         STREAM: begin
            if (accept_c) begin
               remaining_n = remaining - KW'(1);
               if (remaining == KW'(1)) begin
                  state_n = DRAIN;
                  drain_n = CW'(N - 1);
               end
            end
         end
         DRAIN: begin
            if (drain_cnt == '0) state_n = DONE;
            else                 drain_n = drain_cnt - CW'(1);
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Lane i is i+1 stages deep; non-accepted cycles inject zero-data bubbles.
   for (genvar i = 0; i < int'(N); i++) begin : g_lane
      skew_line #(.DELAY(i + 1), .W(WORD_W)) u_a (
         .clk      (clk),
         .rst      (rst),
         .en_in    (accept_c),
         .data_in  (accept_c ? a_vec[WORD_W*i +: WORD_W] : '0),
         .en_out   (enleft[i]),
         .data_out (a_left[WORD_W*i +: WORD_W])
      );
      skew_line #(.DELAY(i + 1), .W(WORD_W)) u_b (
         .clk      (clk),
         .rst      (rst),
         .en_in    (accept_c),
         .data_in  (accept_c ? b_vec[WORD_W*i +: WORD_W] : '0),
         .en_out   (enup[i]),
         .data_out (in_b_above[WORD_W*i +: WORD_W])
      );
   end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: timeline reference model plus negedge monitor.
module tb_systolic_skew_feeder;
   import params::*;

   logic                clk;
   logic                rst;
   logic                start;
   logic [KW-1:0]       k_len;
   full_type_t          compute_type;
   logic                in_valid;
   logic                in_ready;
   logic [WORD_W*N-1:0] a_vec, b_vec, a_left, in_b_above;
   logic [N-1:0]        enleft, enup;
   full_type_t          compute_type_out;
   logic                busy, done;

   systolic_skew_feeder dut (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len), .compute_type(compute_type),
      .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
      .a_left(a_left), .enleft(enleft), .in_b_above(in_b_above), .enup(enup),
      .compute_type_out(compute_type_out), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [31:0] data;
   } exp_t;

   exp_t       qa [N][$];
   exp_t       qb [N][$];
   int         dq [$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   bit         armed = 1'b0;
   bit         m_stream = 1'b0;
   int         m_left = 0;
   int         m_busy_to = -10;
   full_type_t m_type = FT_INT8;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: edge n accepting a beat shows it on lane i in the cycle after edge n+i;
   // the last beat at edge n yields done after edge n+N; IDLE resumes two edges after done.
   initial forever begin
      @(posedge clk);
      cyc   = cyc + 1;
      armed = 1'b1;
      if (!rst) begin
         for (int i = 0; i < int'(N); i++) begin
            qa[i].delete();
            qb[i].delete();
         end
         dq.delete();
         m_stream  = 1'b0;
         m_left    = 0;
         m_type    = FT_INT8;
         m_busy_to = cyc - 1;
      end else if (m_stream) begin
         if (in_valid) begin
            for (int i = 0; i < int'(N); i++) begin
               exp_t e;
               e.cyc  = cyc + i;
               e.data = a_vec[32*i +: 32];
               qa[i].push_back(e);
               e.data = b_vec[32*i +: 32];
               qb[i].push_back(e);
            end
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_stream  = 1'b0;
               m_busy_to = cyc + int'(N);
               dq.push_back(cyc + int'(N));
            end
         end
      end else if (cyc > m_busy_to + 1 && start) begin
         if (k_len == '0) begin
            m_busy_to = cyc;
            dq.push_back(cyc);
         end else begin
            m_stream = 1'b1;
            m_left   = int'(k_len);
            m_type   = compute_type;
         end
      end
   end

   // Monitor: compares every lane, the handshake and the done pulse each cycle.
   initial forever begin
      @(negedge clk);
      if (armed) begin
         chk("in_ready", in_ready, m_stream);
         chk("busy", busy, m_stream || cyc <= m_busy_to);
         chk("compute_type_out", compute_type_out, m_type);
         for (int i = 0; i < int'(N); i++) begin
            exp_t e;
            if (enleft[i]) begin
               if (qa[i].size() == 0) chk($sformatf("enleft%0d_spurious", i), enleft[i], 0);
               else begin
                  e = qa[i].pop_front();
                  chk($sformatf("a%0d_cycle", i), cyc, e.cyc);
                  chk($sformatf("a%0d_data", i), a_left[32*i +: 32], e.data);
               end
            end else begin
               chk($sformatf("a%0d_bubble", i), a_left[32*i +: 32], 0);
               if (qa[i].size() > 0 && qa[i][0].cyc < cyc) begin
                  chk($sformatf("enleft%0d_missing", i), enleft[i], 1);
                  void'(qa[i].pop_front());
               end
            end
            if (enup[i]) begin
               if (qb[i].size() == 0) chk($sformatf("enup%0d_spurious", i), enup[i], 0);
               else begin
                  e = qb[i].pop_front();
                  chk($sformatf("b%0d_cycle", i), cyc, e.cyc);
                  chk($sformatf("b%0d_data", i), in_b_above[32*i +: 32], e.data);
               end
            end else begin
               chk($sformatf("b%0d_bubble", i), in_b_above[32*i +: 32], 0);
               if (qb[i].size() > 0 && qb[i][0].cyc < cyc) begin
                  chk($sformatf("enup%0d_missing", i), enup[i], 1);
                  void'(qb[i].pop_front());
               end
            end
         end
         if (done) begin
            if (dq.size() == 0) chk("done_spurious", done, 0);
            else                chk("done_cycle", cyc, dq.pop_front());
         end else if (dq.size() > 0 && dq[0] < cyc) begin
            chk("done_missing", done, 1);
            void'(dq.pop_front());
         end
      end
   end

   task automatic drive_words(input int beat, input bit directed);
      for (int i = 0; i < int'(N); i++) begin
         a_vec[32*i +: 32] = directed ? 32'(32'h100 * beat + i) : $urandom();
         b_vec[32*i +: 32] = directed ? 32'(32'hB000_0000 + 32'h100 * beat + i) : $urandom();
      end
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_a_left"}, a_left, 0);
      chk({tag, "_in_b_above"}, in_b_above, 0);
      chk({tag, "_enleft"}, enleft, 0);
      chk({tag, "_enup"}, enup, 0);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_type"}, compute_type_out, 0);
   endtask

   // mode 0: always valid, directed data; 1: valid 1,0,1,0,1; 2: random; 3: start+valid held in DRAIN
   task automatic run_tile(input int k, input int mode);
      int       acc = 0;
      int       step = 0;
      bit       v;
      bit [4:0] pat = 5'b10101;
      @(negedge clk);
      start        = 1'b1;
      k_len        = KW'(k);
      compute_type = full_type_t'($urandom_range(0, 5));
      in_valid     = 1'b0;
      @(negedge clk);
      start = 1'b0;
      while (!done && step < 4 * int'(K_MAX) + 64) begin
         case (mode)
            0, 3:    v = 1'b1;
            1:       v = (step < 5) ? pat[step] : 1'b0;
            default: v = ($urandom_range(0, 99) < 70);
         endcase
         if (mode == 3 && acc >= k) start = 1'b1;
         in_valid = v;
         drive_words(acc, mode < 2);
         if (v && in_ready) acc++;
         step++;
         @(negedge clk);
      end
      if (!done) chk("done_timeout", done, 1);
      chk("accept_count", acc, k);
      start    = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      int acc;
      int guard;
      rst = 1'b0; start = 1'b0; k_len = '0; compute_type = FT_INT8;
      in_valid = 1'b1; a_vec = '1; b_vec = '1;
      repeat (3) @(negedge clk);
      check_quiet("reset");
      rst = 1'b1; in_valid = 1'b0;

      run_tile(4, 0);
      run_tile(3, 1);
      run_tile(0, 0);
      run_tile(5, 3);

      // reset after two of five beats
      @(negedge clk);
      start = 1'b1; k_len = KW'(5); compute_type = FT_FP16;
      @(negedge clk);
      start = 1'b0; acc = 0; guard = 0;
      while (acc < 2 && guard < 20) begin
         in_valid = 1'b1;
         drive_words(acc, 1'b0);
         if (in_ready) acc++;
         guard++;
         @(negedge clk);
      end
      chk("mid_tile_accepts", acc, 2);
      rst = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      check_quiet("mid_reset");
      rst = 1'b1; in_valid = 1'b0;
      repeat (12) @(negedge clk);
      run_tile(1, 0);

      for (int t = 0; t < 25; t++)
         run_tile(($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12)), 2);
      run_tile(int'(K_MAX), 2);

      repeat (int'(N) + 4) @(negedge clk);
      for (int i = 0; i < int'(N); i++) begin
         chk($sformatf("a%0d_pending", i), qa[i].size(), 0);
         chk($sformatf("b%0d_pending", i), qb[i].size(), 0);
      end
      chk("done_pending", dq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Upstream feeder for the PE systolic array. Accepts one k-slice per beat (N words of A, one per array row, and N words of B, one per array column) over a valid/ready handshake. Skews each lane by its index, so row i's left-edge PE and column j's top-edge PE receive beat k on the diagonal schedule the array expects. Frames each tile with a start/done protocol and a drain phase.

## Interface
- N, 8, array dimension (rows = columns = lanes)
- K_MAX, 256, maximum beats per tile; KW = $clog2(K_MAX+1)

- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
- start  in  1  begin tile; honoured only in IDLE
- k_len  in  KW  beats in tile, sampled with start
- compute_type  in  params::full_type_t  tile data type, sampled with start
- in_valid  in  1  a_vec/b_vec valid
- in_ready  out  1  feeder accepts a beat this cycle
- a_vec  in  32*N  word i → array row i
- b_vec  in  32*N  word j → array column j
- a_left  out  32*N  word i to enleft-side data of row-0-column PE i
- enleft  out  N  lane valid, row i
- in_b_above  out  32*N  word j to top PE of column j
- enup  out  N  lane valid, column j
- compute_type_out  out  params::full_type_t  latched tile type
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at tile end

## Operation
- States: IDLE → STREAM → DRAIN → DONE → IDLE.
- IDLE: in_ready=0. On start with k_len≠0, latch k_len into remaining and compute_type into compute_type_out, then go to STREAM. On start with k_len=0, go to DONE directly; no lane ever asserts en.
- STREAM: in_ready=1. A beat is accepted when in_valid&&in_ready; each accepted beat decrements remaining. If in_valid is low, a bubble (en=0, data=0) enters every lane. The beat that makes remaining=0 moves the FSM to DRAIN, with the drain counter loaded to N-1.
- DRAIN: in_ready=0. Bubbles are shifted in. The counter decrements each cycle; at 0, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. compute_type_out holds its value until the next start.
- Lane delay: lane i (both A row i and B column i) is a delay line of i+1 registers of {en, data[31:0]}. Data is passed unmodified; no arithmetic.
- start outside IDLE is ignored. in_valid outside STREAM is ignored; the beat is not consumed.

## Timing
- Beat accepted at edge t: it appears on a_left[i]/enleft[i] and in_b_above[i]/enup[i] during cycle t+1+i.
- Last beat accepted at edge t: DRAIN occupies cycles t+1..t+N, and done is high in cycle t+N+1, one cycle after lane N-1 presents the last beat.
- For k_len=0: start sampled at t, done is high in cycle t+1.
- Reset (rst=0 at an edge), including mid-tile: state=IDLE, all delay registers cleared, so a_left=0, in_b_above=0, enleft=0, enup=0. Also in_ready=0, busy=0, done=0, compute_type_out=0 and remaining=0. In-flight beats are dropped and no done is issued.
- in_ready is a function of state only, with no combinational path from in_valid.

## Structure
- The params package gains feeder_state_t (IDLE, STREAM, DRAIN, DONE) and the KW width constant alongside full_type_t.
- Sub-module skew_line #(DELAY) is a {en,data} shift register of DELAY stages with synchronous active-low clear. It is instantiated 2N times via generate, with DELAY=i+1.

## Test plan
- Reset: hold rst=0 for 3 cycles with in_valid=1 → all outputs 0, in_ready=0.
- Single tile, k_len=4, in_valid=1 continuously, a_vec word i = 0x100*k+i → enleft[i] high during cycles t0+1+i..t0+4+i with a_left[i]=0x100*k+i. done is high in cycle t_last+N+1, i.e. exactly N+1 cycles after the 4th accept.
- Bubbles: k_len=3 with in_valid pattern 1,0,1,0,1 → exactly 3 accepts. Each lane shows en pattern 1,0,1,0,1 shifted by i+1, with data 0 on the bubbles.
- k_len=0: start → done in the next cycle, no en asserted, busy high for exactly 1 cycle.
- start and in_valid asserted during DRAIN → both ignored, k count unchanged, a single done.
- Reset asserted in STREAM after 2 of 5 beats → outputs zero on the next cycle. No done follows. A new start with k_len=1 then completes normally.
